// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StGap   = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   off;

    // Rotate so that bit 0 of req_rot is the highest-priority requester.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + off;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold timeout and a one-cycle hand-over gap;
// sel/en feed a 2-to-4 decoder that forms the one-hot grant lines.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             en,
    output logic [IDX_W-1:0] sel,
    output logic             timeout,
    output logic [IDX_W-1:0] ptr_dbg
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t        state_q, state_d;
    logic              en_q, en_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_req;
    logic              hold_last;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_req = req[sel_q];
    assign hold_last = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StGrant;
                    en_d    = 1'b1;
                    sel_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (done || !owner_req || hold_last) begin
                    state_d   = StGap;
                    en_d      = 1'b0;
                    ptr_d     = sel_q + IDX_W'(1);
                    // A release by done or request drop takes precedence over the timeout.
                    timeout_d = hold_last && !done && owner_req;
                end
            end
            StGap: begin
                state_d = StIdle;
                en_d    = 1'b0;
            end
            default: begin
                state_d = StIdle;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            sel_q     <= '0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign en      = en_q;
    assign sel     = sel_q;
    assign timeout = timeout_q;
    assign ptr_dbg = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: expected grants/timeouts queued by stimulus, checked by monitor.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       en;
    logic [1:0] sel;
    logic       timeout;
    logic [1:0] ptr_dbg;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int tq[$];

    rr_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .en      (en),
        .sel     (sel),
        .timeout (timeout),
        .ptr_dbg (ptr_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(output int lows);
        lows = 0;
        while (!en && lows < 20) begin
            lows++;
            tick(1);
        end
        checks++;
        if (!en) begin
            failures++;
            $display("FAIL wait_en: got en=0 expected en=1 within 20 cycles");
        end
    endtask

    // Monitor: a rising en is a new grant; a timeout must coincide with en falling.
    initial begin
        logic en_prev;
        int   e;
        en_prev = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                en_prev = 1'b0;
            end else begin
                if (en && !en_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL grant_unexpected: got sel=%0d expected no grant", sel);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_sel", int'(sel), e);
                    end
                end
                if (timeout) begin
                    chk("timeout_with_en_fall", int'(en_prev && !en), 1);
                    if (tq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL timeout_unexpected: got timeout=1 expected 0");
                    end else begin
                        void'(tq.pop_front());
                    end
                end
                en_prev = en;
            end
        end
    end

    initial begin
        int lows;
        int hi;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick(2);
        chk("reset_en", int'(en), 0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk("reset_ptr", int'(ptr_dbg), 0);
        rst_n = 1'b1;
        tick(1);

        // Single requester, release by dropping the request.
        exp_q.push_back(0);
        req = 4'b0001;
        tick(1);
        chk("latency_en", int'(en), 1);
        req = 4'b0000;
        tick(1);
        chk("drop_gap_en", int'(en), 0);
        chk("ptr_after_drop", int'(ptr_dbg), 1);
        tick(1);

        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // All requesting, done on the second grant cycle: strict rotation.
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_en(lows);
            if (k > 0) chk("handover_gap", lows, 2);
            tick(1);
            done = 1'b1;
            tick(1);
            done = 1'b0;
        end
        req = 4'b0000;
        tick(2);

        // Timeout after MAX_HOLD cycles, then re-grant; then done on the limit cycle.
        exp_q.push_back(2);
        exp_q.push_back(2);
        tq.push_back(1);
        req = 4'b0100;
        wait_en(lows);
        hi = 0;
        while (en && hi < 20) begin
            hi++;
            tick(1);
        end
        chk("hold_cycles", hi, 8);
        chk("timeout_pulse", int'(timeout), 1);
        wait_en(lows);
        chk("regrant_gap", lows, 2);
        tick(7);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = 4'b0000;
        chk("done_at_limit_en", int'(en), 0);
        chk("done_at_limit_timeout", int'(timeout), 0);
        chk("ptr_after_done_limit", int'(ptr_dbg), 3);
        tick(2);

        // Previous owner re-requests alongside requester 3.
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(1);
        req = 4'b0010;
        wait_en(lows);
        req  = 4'b1010;
        done = 1'b1;
        tick(1);
        done = 1'b0;
        wait_en(lows);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        wait_en(lows);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = 4'b0000;
        chk("ptr_after_rerequest", int'(ptr_dbg), 2);
        tick(2);

        // Partial-cycle reset in the middle of a grant.
        exp_q.push_back(2);
        exp_q.push_back(2);
        req = 4'b0100;
        wait_en(lows);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_en", int'(en), 0);
        chk("midreset_sel", int'(sel), 0);
        chk("midreset_timeout", int'(timeout), 0);
        chk("midreset_ptr", int'(ptr_dbg), 0);
        #1 rst_n = 1'b1;
        chk("ptr_before_regrant", int'(ptr_dbg), 0);
        tick(1);
        chk("regrant_after_reset_en", int'(en), 1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = 4'b0000;
        tick(3);

        chk("grant_queue_empty", exp_q.size(), 0);
        chk("timeout_queue_empty", tq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
